// File: rtl/rvm_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rvm_fetch_ctrl
// Description : Fetch sequencer for the rvm fetch/decode unit. Owns the PC,
//               issues one instruction fetch at a time, presents decoded
//               instructions to the execute unit, and raises traps for bus
//               errors, fetch timeouts, illegal opcodes and misaligned
//               branch targets.
// Revision    : 1.0 - initial release
// ============================================================================
module rvm_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0010,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_valid,
  input  logic        mem_error,
  input  logic        fdu_illegal,
  output logic        dec_valid,
  input  logic        exu_ready,
  input  logic        exu_done,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  output logic [31:0] pc,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  localparam int unsigned       TCW     = $clog2(TIMEOUT);
  localparam logic [TCW-1:0]    TC_LAST = TCW'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_BUS   = 2'd0;
  localparam logic [1:0] CAUSE_TMO   = 2'd1;
  localparam logic [1:0] CAUSE_ILL   = 2'd2;
  localparam logic [1:0] CAUSE_ALIGN = 2'd3;

  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_WAIT = 3'd1,
    S_DEC  = 3'd2,
    S_DISP = 3'd3,
    S_EXEC = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     instret_q, instret_d;
  logic [TCW-1:0]  tcount_q, tcount_d;
  // Low for the first cycle after reset so the request only rises one clock
  // after reset release.
  logic            run_q, run_d;

  // State, PC, retire counter and timeout counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      instret_q <= 32'd0;
      tcount_q  <= '0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
      tcount_q  <= tcount_d;
      run_q     <= run_d;
    end
  end

  // Next-state, PC update and output decode; trap is a Mealy output so it
  // appears in the same cycle the faulting condition is seen.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instret_d  = instret_q;
    tcount_d   = tcount_q;
    run_d      = 1'b1;
    mem_req    = 1'b0;
    dec_valid  = 1'b0;
    trap       = 1'b0;
    trap_cause = CAUSE_BUS;

    case (state_q)
      S_REQ: begin
        if (run_q) begin
          mem_req = 1'b1;
          if (mem_gnt) begin
            state_d  = S_WAIT;
            tcount_d = '0;
          end
        end
      end
      S_WAIT: begin
        // A bus error takes priority over a simultaneous valid strobe.
        if (mem_error) begin
          trap       = 1'b1;
          trap_cause = CAUSE_BUS;
        end else if (mem_valid) begin
          state_d = S_DEC;
        end else if (tcount_q == TC_LAST) begin
          trap       = 1'b1;
          trap_cause = CAUSE_TMO;
        end else begin
          tcount_d = tcount_q + 1'b1;
        end
      end
      S_DEC: begin
        // Decoder outputs settle during this cycle.
        if (fdu_illegal) begin
          trap       = 1'b1;
          trap_cause = CAUSE_ILL;
        end else begin
          state_d = S_DISP;
        end
      end
      S_DISP: begin
        dec_valid = 1'b1;
        if (exu_ready) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exu_done) begin
          if (pc_load && (pc_target[1:0] != 2'b00)) begin
            trap       = 1'b1;
            trap_cause = CAUSE_ALIGN;
          end else begin
            pc_d      = pc_load ? pc_target : (pc_q + 32'd4);
            instret_d = instret_q + 32'd1;
            state_d   = S_REQ;
          end
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    if (trap) begin
      pc_d    = TRAP_VEC;
      state_d = S_REQ;
    end

    mem_addr = mem_req ? pc_q : 32'h0;
  end

  assign pc      = pc_q;
  assign instret = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_rvm_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvm_fetch_ctrl
// Description : Self-checking bench for rvm_fetch_ctrl. A transaction-level
//               model tracks the expected PC and retire count; each task
//               drives one scenario and compares DUT outputs inline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvm_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0010;
  localparam int          TIMEOUT  = 8;

  // Transaction kinds
  localparam int K_OK  = 0;
  localparam int K_TMO = 1;
  localparam int K_ERR = 2;
  localparam int K_ILL = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_error = 1'b0;
  logic        fdu_illegal = 1'b0;
  logic        dec_valid;
  logic        exu_ready = 1'b0;
  logic        exu_done = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_target = 32'h0;
  logic [31:0] pc;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  int          n_tests = 0;
  int          n_fail  = 0;

  // Reference model state
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_instret = 32'd0;

  rvm_fetch_ctrl #(
    .RESET_PC (RESET_PC),
    .TRAP_VEC (TRAP_VEC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_valid   (mem_valid),
    .mem_error   (mem_error),
    .fdu_illegal (fdu_illegal),
    .dec_valid   (dec_valid),
    .exu_ready   (exu_ready),
    .exu_done    (exu_done),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .pc          (pc),
    .trap        (trap),
    .trap_cause  (trap_cause),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    mem_gnt     = 1'b0;
    mem_valid   = 1'b0;
    mem_error   = 1'b0;
    fdu_illegal = 1'b0;
    exu_ready   = 1'b0;
    exu_done    = 1'b0;
    pc_load     = 1'b0;
    pc_target   = 32'h0;
  endtask

  // One complete fetch transaction; starts and ends on a falling edge with
  // the DUT expected to be requesting at exp_pc.
  task automatic run_instr(input int gnt_dly, input int val_dly, input int kind,
                           input int rdy_dly, input int done_dly, input logic ld,
                           input logic [31:0] tgt, input logic noise);
    logic [3:0] s;
    logic       mis;
    for (int i = 0; i < 4 && mem_req !== 1'b1; i++) @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b1 || mem_addr !== exp_pc) begin
      n_fail++;
      $display("FAIL fetch_addr: req=%b addr=%h expected req=1 addr=%h", mem_req, mem_addr, exp_pc);
    end
    // Request held while grant is withheld; unrelated inputs must be ignored.
    for (int i = 0; i < gnt_dly; i++) begin
      if (noise) begin
        s = 4'($urandom);
        mem_valid = s[0]; mem_error = s[1]; exu_ready = s[2]; exu_done = s[3];
        pc_load = 1'b1; pc_target = $urandom; fdu_illegal = s[0];
      end
      @(negedge clk);
      n_tests++;
      if (mem_req !== 1'b1 || mem_addr !== exp_pc || trap !== 1'b0) begin
        n_fail++;
        $display("FAIL req_hold: req=%b addr=%h trap=%b expected 1/%h/0", mem_req, mem_addr, trap, exp_pc);
      end
    end
    clear_inputs();
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;

    if (kind == K_TMO) begin
      for (int i = 0; i < TIMEOUT - 1; i++) begin
        #1;
        n_tests++;
        if (trap !== 1'b0 || mem_req !== 1'b0) begin
          n_fail++;
          $display("FAIL wait_quiet: trap=%b req=%b expected 0/0 at wait cycle %0d", trap, mem_req, i);
        end
        @(negedge clk);
      end
      #1;
      n_tests++;
      if (trap !== 1'b1 || trap_cause !== 2'd1) begin
        n_fail++;
        $display("FAIL timeout_trap: trap=%b cause=%0d expected 1/1", trap, trap_cause);
      end
      exp_pc = TRAP_VEC;
      @(negedge clk);
    end else begin
      for (int i = 0; i < val_dly; i++) begin
        #1;
        n_tests++;
        if (trap !== 1'b0 || mem_req !== 1'b0) begin
          n_fail++;
          $display("FAIL wait_quiet: trap=%b req=%b expected 0/0", trap, mem_req);
        end
        @(negedge clk);
      end
      mem_valid = 1'b1;
      mem_error = (kind == K_ERR);
      #1;
      n_tests++;
      if (kind == K_ERR) begin
        if (trap !== 1'b1 || trap_cause !== 2'd0) begin
          n_fail++;
          $display("FAIL bus_error_trap: trap=%b cause=%0d expected 1/0", trap, trap_cause);
        end
        exp_pc = TRAP_VEC;
        @(negedge clk);
        clear_inputs();
      end else begin
        if (trap !== 1'b0) begin
          n_fail++;
          $display("FAIL valid_no_trap: trap=%b expected 0", trap);
        end
        @(negedge clk);
        clear_inputs();
        // Decode cycle
        fdu_illegal = (kind == K_ILL);
        #1;
        n_tests++;
        if (kind == K_ILL) begin
          if (trap !== 1'b1 || trap_cause !== 2'd2 || dec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_trap: trap=%b cause=%0d dec_valid=%b expected 1/2/0", trap, trap_cause, dec_valid);
          end
          exp_pc = TRAP_VEC;
          @(negedge clk);
          clear_inputs();
          n_tests++;
          if (dec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_no_dispatch: dec_valid=%b expected 0", dec_valid);
          end
        end else begin
          if (trap !== 1'b0 || dec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL decode_cycle: trap=%b dec_valid=%b expected 0/0", trap, dec_valid);
          end
          @(negedge clk);
          clear_inputs();
          // Dispatch: dec_valid held until exu_ready
          for (int i = 0; i < rdy_dly; i++) begin
            n_tests++;
            if (dec_valid !== 1'b1 || trap !== 1'b0) begin
              n_fail++;
              $display("FAIL disp_hold: dec_valid=%b trap=%b expected 1/0", dec_valid, trap);
            end
            if (noise) begin
              s = 4'($urandom);
              mem_valid = s[0]; mem_error = s[1]; mem_gnt = s[2]; exu_done = s[3]; pc_load = s[3];
            end
            @(negedge clk);
          end
          clear_inputs();
          n_tests++;
          if (dec_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL dec_valid: dec_valid=%b expected 1", dec_valid);
          end
          exu_ready = 1'b1;
          @(negedge clk);
          exu_ready = 1'b0;
          n_tests++;
          if (dec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL dec_valid_drop: dec_valid=%b expected 0", dec_valid);
          end
          for (int i = 0; i < done_dly; i++) begin
            @(negedge clk);
            n_tests++;
            if (trap !== 1'b0 || mem_req !== 1'b0) begin
              n_fail++;
              $display("FAIL exec_wait: trap=%b req=%b expected 0/0", trap, mem_req);
            end
          end
          exu_done = 1'b1;
          pc_load = ld;
          pc_target = tgt;
          #1;
          mis = ld && (tgt[1:0] != 2'b00);
          n_tests++;
          if (trap !== mis || (mis && trap_cause !== 2'd3)) begin
            n_fail++;
            $display("FAIL retire_trap: trap=%b cause=%0d expected trap=%b cause=3", trap, trap_cause, mis);
          end
          if (mis) begin
            exp_pc = TRAP_VEC;
          end else begin
            exp_pc = ld ? tgt : exp_pc + 32'd4;
            exp_instret = exp_instret + 32'd1;
          end
          @(negedge clk);
          clear_inputs();
        end
      end
    end
    n_tests++;
    if (pc !== exp_pc || instret !== exp_instret) begin
      n_fail++;
      $display("FAIL pc_instret: pc=%h instret=%0d expected %h/%0d", pc, instret, exp_pc, exp_instret);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    n_tests++;
    if (pc !== RESET_PC || instret !== 32'd0 || mem_req !== 1'b0 || mem_addr !== 32'h0 ||
        dec_valid !== 1'b0 || trap !== 1'b0 || trap_cause !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h instret=%0d req=%b addr=%h dv=%b trap=%b cause=%0d expected %h/0/0/0/0/0/0",
               pc, instret, mem_req, mem_addr, dec_valid, trap, trap_cause, RESET_PC);
    end
    resetn = 1'b1;
    #1;
    n_tests++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_req: req=%b expected 0 before first clock", mem_req);
    end
    @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL first_req: req=%b addr=%h expected 1/%h", mem_req, mem_addr, RESET_PC);
    end
    exp_pc = RESET_PC;
    exp_instret = 32'd0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) run_instr(1, 0, K_OK, 0, 0, 1'b0, 32'h0, 1'b0);
    n_tests++;
    if (instret !== 32'd3 || mem_addr !== 32'hC) begin
      n_fail++;
      $display("FAIL sequential: instret=%0d addr=%h expected 3/0000000c", instret, mem_addr);
    end
  endtask

  task automatic test_gnt_delay();
    run_instr(5, 0, K_OK, 0, 0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_timeout();
    run_instr(0, 0, K_TMO, 0, 0, 1'b0, 32'h0, 1'b0);
    n_tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL timeout_refetch: req=%b addr=%h expected 1/00000010", mem_req, mem_addr);
    end
  endtask

  task automatic test_error_valid();
    run_instr(0, 2, K_ERR, 0, 0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_illegal();
    run_instr(0, 0, K_ILL, 0, 0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_branch();
    logic [31:0] ir;
    run_instr(0, 0, K_OK, 1, 2, 1'b1, 32'h100, 1'b0);
    n_tests++;
    if (mem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL branch_target: addr=%h expected 00000100", mem_addr);
    end
    ir = instret;
    run_instr(0, 0, K_OK, 0, 0, 1'b1, 32'h102, 1'b0);
    n_tests++;
    if (instret !== ir || mem_addr !== TRAP_VEC) begin
      n_fail++;
      $display("FAIL misaligned: instret=%0d addr=%h expected %0d/%h", instret, mem_addr, ir, TRAP_VEC);
    end
  endtask

  task automatic test_wrap();
    run_instr(0, 0, K_OK, 0, 0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    run_instr(0, 0, K_OK, 0, 0, 1'b0, 32'h0, 1'b0);
    n_tests++;
    if (mem_addr !== 32'h0 || pc !== 32'h0) begin
      n_fail++;
      $display("FAIL pc_wrap: addr=%h pc=%h expected 0/0", mem_addr, pc);
    end
  endtask

  task automatic test_reset_mid();
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    n_tests++;
    if (pc !== RESET_PC || instret !== 32'd0 || mem_req !== 1'b0 || trap !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h instret=%0d req=%b trap=%b expected %h/0/0/0", pc, instret, mem_req, trap, RESET_PC);
    end
    @(negedge clk);
    resetn = 1'b1;
    mem_valid = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    n_tests++;
    if (mem_req !== 1'b1 || mem_addr !== RESET_PC || trap !== 1'b0 || dec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_valid: req=%b addr=%h trap=%b dv=%b expected 1/%h/0/0", mem_req, mem_addr, trap, dec_valid, RESET_PC);
    end
    @(negedge clk);
    exp_pc = RESET_PC;
    exp_instret = 32'd0;
    run_instr(0, 0, K_OK, 0, 0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_random();
    int          r;
    int          kind;
    logic [31:0] tgt;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      kind = (r == 0) ? K_TMO : (r == 1) ? K_ERR : (r == 2) ? K_ILL : K_OK;
      tgt = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      run_instr($urandom_range(0, 3), $urandom_range(0, TIMEOUT - 1), kind,
                $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), tgt, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_gnt_delay();
    test_timeout();
    test_error_valid();
    test_illegal();
    test_branch();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
